// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder, time-shared by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa_cell plus carry flop, LSB first.
// Optional subtract mode (sub port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             sub_en;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at res_sr[0].
  assign res_next = WIDTH'({s, res_sr} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the carry flop seeds the +1.
            a_sr  <= a;
            b_sr  <= sub_en ? ~b : b;
            carry <= sub_en ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= c;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop adds two WIDTH-bit operands LSB-first over WIDTH cycles.
- Next generation of the team's single-bit combinational full adder: generalised in width, sequenced by an FSM, with start/busy/done handshake.
- Sits in area-constrained datapaths where one adder cell is time-shared instead of a WIDTH-bit ripple-carry array.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on accepted start.
- b  input  WIDTH  operand B; sampled on accepted start.
- cin  input  1  carry-in; sampled on accepted start.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, all internal shift registers, carry flop and bit counter = 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE to SHIFT: on an edge with start=1, load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0.
- SHIFT, each cycle:
  - fa_cell computes s and c from a_sr[0], b_sr[0] and carry.
  - res_sr <= {s, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; carry <= c; cnt++.
  - When cnt==WIDTH-1: sum <= {s, res_sr[WIDTH-1:1]}, cout <= c, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start accepted at edge T; done is high in the cycle after edge T+WIDTH+1; busy is high for WIDTH+1 cycles.
- sum/cout hold their values until the next computation completes. They do not change during SHIFT.
- start while busy (SHIFT or DONE) is ignored, not queued. Operand changes after acceptance have no effect.
- Back-to-back operation: start held high causes re-acceptance in the first IDLE cycle after DONE. Minimum spacing is WIDTH+2 cycles.
- WIDTH=1: one SHIFT cycle, then DONE.
- Reset asserted mid-operation: immediate abort to the reset values above; no done pulse is produced.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1 loads b_sr<=~b and carry<=1; cin is ignored.
  - Result: {cout,sum} = a + ~b + 1, i.e. sum = a-b mod 2^WIDTH, with cout=1 meaning no borrow.
  - sub=0 gives normal add.
- Undefined: no sub port; add only. Logic is identical to sub tied to 0.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - function cnt_w(WIDTH) = $clog2(WIDTH) with a minimum of 1.
- Sub-module fa_cell: purely combinational 1-bit full adder (a, b, ci to s, co), sum = XOR of three inputs, carry = majority. Instantiated once.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0, start pulse: busy for 9 cycles, done one cycle later, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0: sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1: sum=0x00, cout=1.
- Start pulses during SHIFT and DONE with different operands: ignored; result of the first operation only; exactly one done pulse.
- Assert rst_n=0 at SHIFT cycle 4 of 0x3C+0x0F: busy=0, done=0, sum=0, cout=0 immediately; next op 0x3C+0x0F gives sum=0x4B, cout=0.
- SERIAL_ADDER_SUB_EN: 0x10-0x01 gives sum=0x0F, cout=1; 0x00-0x01 gives sum=0xFF, cout=0.
- WIDTH=1 and WIDTH=16 builds: random operands (1000 each) checked against a+b+cin; done spacing WIDTH+2 with start held high.
